run_ctrl: RTL and testbench
===========================

Name: run_ctrl

Overview:
- Launch/completion sequencer for the TopLevel core.
- Converts the host Start/Ack handshake into core control: holds the core (PC, fetch) in reset while the host preloads data memory and the register file, releases it to run, and detects the program's halt.
- Reports completion on Ack together with a run-cycle count.
- Sits between the bench/host pins and the core's PC/control logic.

Parameters:
- CNT_W, 16, width of the run-cycle counter.
- WDOG_LIMIT, 1000, maximum RUN cycles before forced completion (used only with the watchdog feature).

Ports:
- Clk  input  1  system clock; all state changes on the rising edge.
- Reset  input  1  asynchronous, active-high reset.
- Start  input  1  host request. High arms/holds the core; the falling edge (Start sampled 0 while ARMED) launches the program.
- Halt  input  1  core's decoded halt/done instruction; sampled only in RUN.
- CoreReset  output  1  holds the core's PC at 0 and the fetch path idle.
- CoreEn  output  1  core advance enable (PC and register-file/data-memory writes).
- Ack  output  1  program complete; high in DONE.
- Busy  output  1  high in RUN.
- Timeout  output  1  completion was forced by the watchdog.
- CycleCnt  output  CNT_W  number of clock edges spent in RUN during the last or current run.

Behaviour:
- Moore FSM; all outputs decode from registered state/counter. No combinational path from any input to any output.
- Reset (any time, including mid-RUN):
  - state=IDLE, CycleCnt=0, Timeout=0, CoreReset=1, CoreEn=0, Ack=0, Busy=0.
  - Reset has priority over every other event.
- IDLE: CoreReset=1, CoreEn=0. Start=1 -> ARMED.
- ARMED:
  - CoreReset=1, CoreEn=0. CycleCnt and Timeout are cleared on entry.
  - Stays while Start=1; the host preloads memories during this window.
  - Start=0 -> RUN.
- RUN:
  - CoreReset=0, CoreEn=1, Busy=1.
  - CycleCnt increments on every edge taken in RUN, including the edge that leaves RUN. Saturates at all-ones; no wrap.
  - Halt=1 -> DONE.
  - Start=1 with Halt=0 -> ARMED (host abort/restart).
  - Start=1 with Halt=1 -> DONE (halt wins).
- DONE:
  - Ack=1, CoreEn=0, CoreReset=0 so core state stays observable. CycleCnt frozen.
  - Start=1 -> ARMED. Ack drops on that edge.
- Latency:
  - Start sampled 0 in ARMED at edge n -> CoreEn=1 after edge n.
  - Halt sampled 1 at edge m -> CoreEn=0 and Ack=1 after edge m.
  - Halt on the k-th RUN cycle gives CycleCnt=k.
- Halt outside RUN is ignored.
- Start held high through reset release -> IDLE for one edge, then ARMED.

Optional Feature:
- Macro: RUN_CTRL_WDOG_EN.
- With it defined:
  - In RUN, if CycleCnt==WDOG_LIMIT-1 and Halt=0 at an edge -> DONE with Timeout=1 and CycleCnt=WDOG_LIMIT.
  - Halt in the same cycle wins (Timeout=0).
  - Timeout clears on entry to ARMED.
- Without it: no watchdog logic; Timeout tied 0; runs are unbounded except by CycleCnt saturation.

Decomposition:
- Package run_ctrl_pkg:
  - state enum IDLE/ARMED/RUN/DONE (2-bit)
  - default CNT_W
  - localparam for the all-ones saturation value
- Sub-module sat_counter: clear, enable, saturate, parameterised width. Instantiated once for CycleCnt.
- FSM and watchdog compare stay in run_ctrl.

Test Plan:
- Reset=1 for 20ns with Start=1, then Reset=0 -> IDLE outputs exact (CoreReset=1, CoreEn=0, Ack=0, CycleCnt=0), then ARMED on the next edge.
- Start 1 for 2 cycles then 0; Halt pulsed on the 32nd RUN cycle -> CoreEn high for exactly 32 cycles, Ack=1 on the following cycle, CycleCnt=32, Timeout=0.
- In DONE, raise Start -> Ack=0 next cycle, CycleCnt=0. Drop Start, Halt after 5 cycles -> CycleCnt=5.
- Start reasserted on RUN cycle 10 with Halt=0 -> ARMED, CoreReset=1, CycleCnt cleared. Start=1 and Halt=1 together -> DONE.
- Assert Reset mid-RUN (CycleCnt=17) -> immediate IDLE outputs without waiting for a clock edge, CycleCnt=0.
- RUN_CTRL_WDOG_EN with WDOG_LIMIT=8, Halt never asserted -> Ack=1, Timeout=1, CycleCnt=8. Repeat with Halt on cycle 8 -> Timeout=0, CycleCnt=8.

Source files
------------

// File: rtl/run_ctrl_pkg.sv
// Shared types and constants for the run_ctrl launch/completion sequencer.
package run_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_RUN   = 2'd2,
    ST_DONE  = 2'd3
  } run_state_e;

  localparam int unsigned CNT_W_DEF = 16;
  localparam logic [CNT_W_DEF-1:0] CNT_SAT = '1;

endpackage

// File: rtl/run_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear; clear has priority over enable.
module sat_counter
  import run_ctrl_pkg::*;
#(
  parameter int unsigned W = CNT_W_DEF
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] cnt
);

  localparam logic [W-1:0] SAT = '1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en && (cnt != SAT)) begin
      cnt <= cnt + W'(1);
    end
  end

endmodule

// File: rtl/run_ctrl.sv
// Host Start/Ack to core control sequencer with run-cycle count.
// Optional watchdog enabled by defining RUN_CTRL_WDOG_EN.
module run_ctrl
  import run_ctrl_pkg::*;
#(
  parameter int unsigned CNT_W      = CNT_W_DEF,
  parameter int unsigned WDOG_LIMIT = 1000
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Start,
  input  logic             Halt,
  output logic             CoreReset,
  output logic             CoreEn,
  output logic             Ack,
  output logic             Busy,
  output logic             Timeout,
  output logic [CNT_W-1:0] CycleCnt
);

  run_state_e state;
  logic       cnt_clr;
  logic       cnt_en;
  logic       wdog_hit;

`ifdef RUN_CTRL_WDOG_EN
  localparam logic [CNT_W-1:0] WDOG_LAST = CNT_W'(WDOG_LIMIT - 1);

  // Forced completion on the edge that would make the count reach the limit.
  assign wdog_hit = (state == ST_RUN) && !Halt && (CycleCnt == WDOG_LAST);
`else
  logic unused_wdog;

  assign unused_wdog = ^WDOG_LIMIT;
  assign wdog_hit    = 1'b0;
`endif

  assign cnt_en = (state == ST_RUN);

  // Counter clears on every entry into ARMED.
  always_comb begin
    cnt_clr = 1'b0;
    case (state)
      ST_IDLE, ST_DONE: cnt_clr = Start;
      ST_RUN:           cnt_clr = Start && !Halt && !wdog_hit;
      default:          cnt_clr = 1'b0;
    endcase
  end

  sat_counter #(
    .W(CNT_W)
  ) u_cycle_cnt (
    .clk(Clk),
    .rst(Reset),
    .clr(cnt_clr),
    .en (cnt_en),
    .cnt(CycleCnt)
  );

  // State and registered outputs move together so outputs never see inputs directly.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state     <= ST_IDLE;
      CoreReset <= 1'b1;
      CoreEn    <= 1'b0;
      Ack       <= 1'b0;
      Busy      <= 1'b0;
      Timeout   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (Start) begin
            state   <= ST_ARMED;
            Timeout <= 1'b0;
          end
        end
        ST_ARMED: begin
          if (!Start) begin
            state     <= ST_RUN;
            CoreReset <= 1'b0;
            CoreEn    <= 1'b1;
            Busy      <= 1'b1;
          end
        end
        ST_RUN: begin
          if (Halt || wdog_hit) begin
            state   <= ST_DONE;
            CoreEn  <= 1'b0;
            Busy    <= 1'b0;
            Ack     <= 1'b1;
            Timeout <= wdog_hit;
          end else if (Start) begin
            state     <= ST_ARMED;
            CoreReset <= 1'b1;
            CoreEn    <= 1'b0;
            Busy      <= 1'b0;
          end
        end
        ST_DONE: begin
          if (Start) begin
            state     <= ST_ARMED;
            CoreReset <= 1'b1;
            Ack       <= 1'b0;
            Timeout   <= 1'b0;
          end
        end
        default: begin
          state     <= ST_IDLE;
          CoreReset <= 1'b1;
          CoreEn    <= 1'b0;
          Ack       <= 1'b0;
          Busy      <= 1'b0;
          Timeout   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_run_ctrl.sv
// Self-checking bench for run_ctrl: phase-level reference model plus directed scenarios.
module tb_run_ctrl;

  localparam int unsigned CNT_W      = 16;
  localparam int unsigned WDOG_LIMIT = 8;
  localparam int          MAXC       = 65535;
`ifdef RUN_CTRL_WDOG_EN
  localparam bit WDOG    = 1'b1;
  localparam int RST_AT  = 5;
`else
  localparam bit WDOG    = 1'b0;
  localparam int RST_AT  = 17;
`endif

  logic             clk   = 1'b0;
  logic             rst   = 1'b0;
  logic             start = 1'b0;
  logic             halt  = 1'b0;
  logic             core_reset, core_en, ack, busy, timeout;
  logic [CNT_W-1:0] cycle_cnt;

  int n_pass  = 0;
  int n_total = 0;

  run_ctrl #(
    .CNT_W     (CNT_W),
    .WDOG_LIMIT(WDOG_LIMIT)
  ) dut (
    .Clk      (clk),
    .Reset    (rst),
    .Start    (start),
    .Halt     (halt),
    .CoreReset(core_reset),
    .CoreEn   (core_en),
    .Ack      (ack),
    .Busy     (busy),
    .Timeout  (timeout),
    .CycleCnt (cycle_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
  endtask

  // Reference model: which phase the host/core pair is in, and how many run edges elapsed.
  bit m_idle, m_armed, m_run, m_done, m_to;
  int m_cnt;

  function automatic int bump(input int v);
    return (v < MAXC) ? v + 1 : MAXC;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_idle <= 1'b1; m_armed <= 1'b0; m_run <= 1'b0; m_done <= 1'b0;
      m_cnt  <= 0;    m_to    <= 1'b0;
    end else if (m_idle) begin
      if (start) begin m_idle <= 1'b0; m_armed <= 1'b1; m_cnt <= 0; m_to <= 1'b0; end
    end else if (m_armed) begin
      if (!start) begin m_armed <= 1'b0; m_run <= 1'b1; end
    end else if (m_run) begin
      if (halt || (WDOG && m_cnt == int'(WDOG_LIMIT) - 1)) begin
        m_run <= 1'b0; m_done <= 1'b1; m_cnt <= bump(m_cnt); m_to <= !halt;
      end else if (start) begin
        m_run <= 1'b0; m_armed <= 1'b1; m_cnt <= 0; m_to <= 1'b0;
      end else begin
        m_cnt <= bump(m_cnt);
      end
    end else if (m_done) begin
      if (start) begin m_done <= 1'b0; m_armed <= 1'b1; m_cnt <= 0; m_to <= 1'b0; end
    end
  end

  always @(negedge clk) begin
    chk("core_reset", 32'(core_reset), 32'(m_idle | m_armed));
    chk("core_en",    32'(core_en),    32'(m_run));
    chk("busy",       32'(busy),       32'(m_run));
    chk("ack",        32'(ack),        32'(m_done));
    chk("timeout",    32'(timeout),    32'(m_to));
    chk("cycle_cnt",  32'(cycle_cnt),  32'(m_cnt));
  end

  task automatic restart();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic run_then_halt(input int k);
    for (int i = 1; i <= k; i++) begin
      @(negedge clk);
      if (i == k) halt = 1'b1;
    end
    @(negedge clk);
    halt = 1'b0;
  endtask

  initial begin
    int en_cycles;
    int waited;

    start = 1'b1;
    #1 rst = 1'b1;
    #19 rst = 1'b0;
    #1;
    chk("rel_core_reset", 32'(core_reset), 32'd1);
    chk("rel_core_en",    32'(core_en),    32'd0);
    chk("rel_ack",        32'(ack),        32'd0);
    chk("rel_cnt",        32'(cycle_cnt),  32'd0);
    @(negedge clk);
    @(negedge clk);
    chk("armed_core_en", 32'(core_en), 32'd0);
    start = 1'b0;

`ifndef RUN_CTRL_WDOG_EN
    en_cycles = 0;
    for (int k = 1; k <= 32; k++) begin
      @(negedge clk);
      if (core_en) en_cycles++;
      if (k == 32) halt = 1'b1;
    end
    @(negedge clk);
    halt = 1'b0;
    chk("run32_en_cycles", 32'(en_cycles), 32'd32);
    chk("run32_core_en",   32'(core_en),   32'd0);
    chk("run32_ack",       32'(ack),       32'd1);
    chk("run32_cnt",       32'(cycle_cnt), 32'd32);
    chk("run32_timeout",   32'(timeout),   32'd0);

    start = 1'b1;
    @(negedge clk);
    chk("rearm_ack", 32'(ack),        32'd0);
    chk("rearm_cnt", 32'(cycle_cnt),  32'd0);
    chk("rearm_rst", 32'(core_reset), 32'd1);
    start = 1'b0;
    run_then_halt(5);
    chk("run5_ack", 32'(ack),       32'd1);
    chk("run5_cnt", 32'(cycle_cnt), 32'd5);

    restart();
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      if (i == 10) start = 1'b1;
    end
    @(negedge clk);
    chk("abort_core_reset", 32'(core_reset), 32'd1);
    chk("abort_core_en",    32'(core_en),    32'd0);
    chk("abort_cnt",        32'(cycle_cnt),  32'd0);
    start = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      if (i == 3) begin start = 1'b1; halt = 1'b1; end
    end
    @(negedge clk);
    start = 1'b0;
    halt  = 1'b0;
    chk("both_ack",     32'(ack),       32'd1);
    chk("both_cnt",     32'(cycle_cnt), 32'd3);
    chk("both_timeout", 32'(timeout),   32'd0);
`else
    waited = 0;
    while (!ack && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    chk("wdog_ack",     32'(ack),       32'd1);
    chk("wdog_timeout", 32'(timeout),   32'd1);
    chk("wdog_cnt",     32'(cycle_cnt), 32'd8);
    chk("wdog_waited",  32'(waited),    32'd9);

    start = 1'b1;
    @(negedge clk);
    chk("wdog_to_clear", 32'(timeout), 32'd0);
    start = 1'b0;
    run_then_halt(8);
    chk("wdog_halt_ack",     32'(ack),       32'd1);
    chk("wdog_halt_timeout", 32'(timeout),   32'd0);
    chk("wdog_halt_cnt",     32'(cycle_cnt), 32'd8);

    restart();
    run_then_halt(5);
    chk("run5_cnt", 32'(cycle_cnt), 32'd5);
`endif

    restart();
    for (int i = 1; i <= RST_AT + 1; i++) @(negedge clk);
    chk("pre_rst_cnt", 32'(cycle_cnt), 32'(RST_AT));
    #2 rst = 1'b1;
    #1;
    chk("async_core_reset", 32'(core_reset), 32'd1);
    chk("async_core_en",    32'(core_en),    32'd0);
    chk("async_busy",       32'(busy),       32'd0);
    chk("async_ack",        32'(ack),        32'd0);
    chk("async_cnt",        32'(cycle_cnt),  32'd0);
    @(negedge clk);
    rst  = 1'b0;
    halt = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("idle_halt_core_reset", 32'(core_reset), 32'd1);
    chk("idle_halt_ack",        32'(ack),        32'd0);
    halt = 1'b0;
    @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL sim_timeout: got running want finished");
    $fatal(1);
  end

endmodule
